// File: rtl/serial_tx_if.sv
// serial_tx_if: valid/ready word handshake between a word source and the serial transmitter.
interface serial_tx_if #(parameter int DATA_W = 8);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  modport master (output tx_data, tx_valid, input tx_ready);
  modport slave  (input tx_data, tx_valid, output tx_ready);
endinterface

// File: rtl/serial_tx.sv
// serial_tx: frames each accepted word as start, LSB-first data, optional parity and stop bits on a registered line.
module serial_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_EN    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  serial_tx_if.slave   s,
  output logic         tx_out,
  output logic         busy,
  output logic         frame_done
);
  localparam int CW = CLKS_PER_BIT > 1 ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] CYC_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t            state_q, state_d;
  logic [CW-1:0]     cyc_q, cyc_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic              par_q, par_d, tx_q, tx_d, done_q, done_d, cyc_end;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    cyc_end = cyc_q == CYC_LAST;
    if (state_q == IDLE) begin
      if (s.tx_valid) begin
        state_d = START;
        shift_d = s.tx_data;
        par_d   = ^s.tx_data ^ 1'(PARITY_ODD);
        cyc_d   = '0;
        bit_d   = '0;
      end
    end else begin
      cyc_d = cyc_end ? '0 : cyc_q + 1'b1;
      if (cyc_end)
        case (state_q)
          START:  state_d = DATA;
          DATA: begin
            shift_d = shift_q >> 1;
            bit_d   = bit_q == BIT_LAST ? '0 : bit_q + 1'b1;
            if (bit_q == BIT_LAST) state_d = PARITY_EN != 0 ? PARITY : STOP;
          end
          PARITY: state_d = STOP;
          default: state_d = IDLE;
        endcase
    end
  end
  // Line value is registered from the upcoming state so tx_out never sees an input combinationally.
  always_comb begin
    tx_d   = state_d == START  ? 1'b0 :
             state_d == DATA   ? shift_d[0] :
             state_d == PARITY ? par_d : 1'b1;
    done_d = state_q == STOP && state_d == IDLE;
  end
  assign s.tx_ready = state_q == IDLE;
  assign busy       = state_q != IDLE;
  assign tx_out     = tx_q;
  assign frame_done = done_q;
endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: three transmitter configurations checked against a bit-list frame model.
module tb_serial_tx;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       vld [3];
  logic [7:0] dat [3];
  logic [2:0] tx, bz, dn, rdy;
  int         checks = 0;
  int         errors = 0;
  int         cpb  [3] = '{4, 1, 3};
  bit         pen  [3] = '{1'b1, 1'b0, 1'b1};
  bit         podd [3] = '{1'b0, 1'b0, 1'b1};

  always #5 clk = ~clk;

  serial_tx_if #(.DATA_W(8)) if0 ();
  serial_tx_if #(.DATA_W(8)) if1 ();
  serial_tx_if #(.DATA_W(8)) if2 ();
  assign if0.tx_valid = vld[0];
  assign if0.tx_data  = dat[0];
  assign if1.tx_valid = vld[1];
  assign if1.tx_data  = dat[1];
  assign if2.tx_valid = vld[2];
  assign if2.tx_data  = dat[2];
  assign rdy = {if2.tx_ready, if1.tx_ready, if0.tx_ready};

  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) u0 (
    .clk(clk), .rst_n(rst_n), .s(if0.slave), .tx_out(tx[0]), .busy(bz[0]), .frame_done(dn[0]));
  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(0), .PARITY_ODD(0)) u1 (
    .clk(clk), .rst_n(rst_n), .s(if1.slave), .tx_out(tx[1]), .busy(bz[1]), .frame_done(dn[1]));
  serial_tx #(.DATA_W(8), .CLKS_PER_BIT(3), .PARITY_EN(1), .PARITY_ODD(1)) u2 (
    .clk(clk), .rst_n(rst_n), .s(if2.slave), .tx_out(tx[2]), .busy(bz[2]), .frame_done(dn[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chk_idle(input int k, input logic done_exp);
    chk("idle_tx", 32'(tx[k]), 32'd1);
    chk("idle_busy", 32'(bz[k]), 32'd0);
    chk("idle_ready", 32'(rdy[k]), 32'd1);
    chk("idle_done", 32'(dn[k]), 32'(done_exp));
  endtask

  // Entered at a negedge with instance k idle (or in its done cycle when chained).
  task automatic run_frame(input int k, input logic [7:0] w, input bit chaos, input bit hold,
                           input logic [7:0] nxt, input int abort_at);
    bit bits[$];
    int n;
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(w[i]);
    if (pen[k]) bits.push_back(^w ^ podd[k]);
    bits.push_back(1'b1);
    n = bits.size() * cpb[k];
    vld[k] = 1'b1;
    dat[k] = w;
    @(posedge clk);
    for (int j = 0; j < n; j++) begin
      @(negedge clk);
      if (j == 0) begin
        vld[k] = hold;
        if (hold) dat[k] = nxt;
      end
      if (chaos && !hold) begin
        dat[k] = 8'($urandom);
        vld[k] = (j == n / 2);
      end
      chk("tx_bit", 32'(tx[k]), 32'(bits[j / cpb[k]]));
      chk("busy", 32'(bz[k]), 32'd1);
      chk("ready", 32'(rdy[k]), 32'd0);
      chk("done_early", 32'(dn[k]), 32'd0);
      if (j == abort_at) begin
        vld[k] = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_tx", 32'(tx[k]), 32'd1);
        chk("rst_busy", 32'(bz[k]), 32'd0);
        chk("rst_done", 32'(dn[k]), 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(negedge clk);
        chk_idle(k, 1'b0);
        return;
      end
    end
    @(negedge clk);
    chk_idle(k, 1'b1);
    if (!hold) begin
      @(negedge clk);
      chk_idle(k, 1'b0);
    end
  endtask

  initial begin
    for (int k = 0; k < 3; k++) begin
      vld[k] = 1'b0;
      dat[k] = 8'h00;
    end
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) chk_idle(k, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(0, 8'hA5, 1'b0, 1'b0, 8'h00, -1);
    run_frame(2, 8'h00, 1'b0, 1'b0, 8'h00, -1);
    run_frame(2, 8'hFF, 1'b0, 1'b0, 8'h00, -1);
    run_frame(0, 8'h01, 1'b0, 1'b0, 8'h00, -1);
    run_frame(0, 8'h3C, 1'b0, 1'b1, 8'hC3, -1);
    run_frame(0, 8'hC3, 1'b0, 1'b0, 8'h00, -1);
    run_frame(0, 8'($urandom), 1'b0, 1'b0, 8'h00, 17);
    run_frame(0, 8'h5A, 1'b0, 1'b0, 8'h00, -1);
    run_frame(1, 8'h81, 1'b0, 1'b0, 8'h00, -1);
    run_frame(0, 8'($urandom), 1'b1, 1'b0, 8'h00, -1);
    run_frame(1, 8'($urandom), 1'b1, 1'b0, 8'h00, -1);
    for (int i = 0; i < 8; i++)
      run_frame(int'($urandom_range(2, 0)), 8'($urandom), 1'($urandom_range(1, 0)), 1'b0, 8'h00, -1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_tx.md
Name: serial_tx

Overview:
Parallel-in, serial-out frame transmitter. It drives a single-wire line that a rising-edge D flip-flop chain samples at the far end. It accepts one data word per valid/ready handshake and sends it as start bit, data bits (LSB first), optional parity bit and stop bit. Each bit is held for a fixed number of clock cycles. It sits between the FSM datapath and the serial line and is the sending end of the team's serial receive path.

Parameters:
DATA_W, 8, data bits per frame (1..32)
CLKS_PER_BIT, 4, clock cycles each line bit is held (>=1)
PARITY_EN, 1, 1 = insert a parity bit after the data bits; 0 = no parity bit
PARITY_ODD, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_EN=0)

Ports:
clk  input  1  clock; all state changes on the rising edge
rst_n  input  1  asynchronous active-low reset
tx_data  input  DATA_W  word to send; sampled only on an accepting edge
tx_valid  input  1  source has a word on tx_data
tx_ready  output  1  block can accept a word (high only in IDLE)
tx_out  output  1  serial line; idles high
busy  output  1  frame in progress (state != IDLE)
frame_done  output  1  one-cycle pulse when a frame completes

Behaviour:
- Reset (rst_n=0) takes effect immediately, without waiting for clk: state=IDLE, tx_out=1, busy=0, frame_done=0, bit and cycle counters=0.
- tx_ready = (state==IDLE). It therefore reads 1 during reset, but no transfer can occur while rst_n=0.
- tx_out is driven straight from a register; there is no combinational path from any input to tx_out.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: tx_out=1. On a rising edge with tx_valid=1 and tx_ready=1 (accept):
  - latch tx_data into the shift register;
  - compute the parity bit: XOR of all data bits, XORed with PARITY_ODD;
  - go to START; tx_out=0 from that edge onward.
- Bit timing: a cycle counter runs 0..CLKS_PER_BIT-1. Each state holds its line value for exactly CLKS_PER_BIT cycles, then advances on the edge where the counter equals CLKS_PER_BIT-1 and wraps to 0.
- START: line=0, then go to DATA.
- DATA: line = shift_reg[0]. At each bit boundary, shift right and increment the bit counter. After DATA_W bits, go to PARITY if PARITY_EN=1, otherwise go to STOP.
- PARITY: line = stored parity bit, then go to STOP.
- STOP: line=1. At the end of the bit, go to IDLE and assert frame_done for exactly the first IDLE cycle.
- Frame length: (2 + DATA_W + PARITY_EN) * CLKS_PER_BIT cycles, counted from the accepting edge to the edge that enters IDLE.
- Back-to-back frames: tx_ready rises in the same cycle frame_done is high. If tx_valid is held high, the next word is accepted on the edge ending that cycle. The minimum gap is one idle-high clock between a stop bit and the next start bit.
- Changes on tx_data or tx_valid while busy=1 are ignored. A word is never dropped silently: the source must hold tx_valid until tx_ready is seen.
- Reset mid-frame aborts the frame: tx_out=1 immediately, no frame_done pulse. After rst_n rises, the block accepts on the first qualifying edge.
- CLKS_PER_BIT=1: each state lasts one cycle and the counter stays at 0; behaviour is otherwise identical.
- Counter widths: cycle counter is clog2(CLKS_PER_BIT) bits (minimum 1); bit counter is clog2(DATA_W+1) bits. Neither may overflow at parameter extremes.

Test Plan:
- Defaults, send 0xA5 with even parity: line is low 4 cycles, then data 1,0,1,0,0,1,0,1 at 4 cycles each, parity 0, stop 1 → 44 cycles total; frame_done pulses once; tx_ready=0 throughout the frame.
- PARITY_ODD=1, send 0x00 → parity bit=1. Send 0xFF → parity bit=1. PARITY_ODD=0, send 0x01 → parity bit=1.
- tx_valid held high with words 0x3C then 0xC3: second start bit begins exactly 1 cycle after the first stop bit ends; accept-to-accept period = 45 cycles; two frame_done pulses; both frames are bit-exact.
- rst_n pulsed low for 1 cycle during DATA bit 3 (asynchronously, mid-clock): tx_out=1 and busy=0 before the next edge; no frame_done. A new word 0x5A is then sent correctly.
- CLKS_PER_BIT=1, PARITY_EN=0, DATA_W=8, send 0x81: 10-cycle frame reading 0,1,0,0,0,0,0,0,1,1.
- tx_data toggled every cycle while busy, and tx_valid pulsed mid-frame: transmitted bits equal the word latched at accept; the mid-frame pulse is not accepted.
